// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 encodings, FSM states
// and the request legality check.
package lsu_pkg;

  localparam int XLEN = 32;
  localparam int BE_W = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  // funct3[1:0] encodes access size (00 byte, 01 half, 10 word) for every legal op.
  function automatic logic lsu_legal(input logic we, input logic [2:0] f3,
                                     input logic [1:0] off);
    logic ok_op;
    logic ok_al;
    if (we) ok_op = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else    ok_op = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                    (f3 == F3_BU) || (f3 == F3_HU);
    case (f3[1:0])
      2'b00:   ok_al = 1'b1;
      2'b01:   ok_al = ~off[0];
      default: ok_al = (off == 2'b00);
    endcase
    return ok_op & ok_al;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store byte enables / replicated write data,
// and load byte/half extraction with sign or zero extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]      st_size_i,
  input  logic [1:0]      st_off_i,
  input  logic [XLEN-1:0] st_data_i,
  output logic [BE_W-1:0] be_o,
  output logic [XLEN-1:0] wdata_o,
  input  logic [2:0]      ld_funct3_i,
  input  logic [1:0]      ld_off_i,
  input  logic [XLEN-1:0] ld_word_i,
  output logic [XLEN-1:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = st_data_i;
    case (st_size_i)
      2'b00: begin
        be_o    = 4'b0001 << st_off_i;
        wdata_o = {4{st_data_i[7:0]}};
      end
      2'b01: begin
        be_o    = st_off_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{st_data_i[15:0]}};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = st_data_i;
      end
    endcase
  end

  always_comb begin
    ld_byte = ld_word_i[7:0];
    case (ld_off_i)
      2'd0: ld_byte = ld_word_i[7:0];
      2'd1: ld_byte = ld_word_i[15:8];
      2'd2: ld_byte = ld_word_i[23:16];
      2'd3: ld_byte = ld_word_i[31:24];
      default: ld_byte = ld_word_i[7:0];
    endcase
    ld_half = ld_off_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
    case (ld_funct3_i)
      F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
      F3_BU:   ld_data_o = {24'd0, ld_byte};
      F3_HU:   ld_data_o = {16'd0, ld_half};
      default: ld_data_o = ld_word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store engine: IDLE -> BUSY -> RESP over a req/ack data memory
// port, stalling the datapath until the access completes, errors or times out.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DataAddrWidth = 10,
  parameter int TimeoutCycles = 15
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  input  logic                     req_we_i,
  input  logic [2:0]               funct3_i,
  input  logic [XLEN-1:0]          addr_i,
  input  logic [XLEN-1:0]          wdata_i,
  output logic                     stall_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [XLEN-1:0]          rdata_o,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [DataAddrWidth-1:0] mem_addr_o,
  output logic [BE_W-1:0]          mem_be_o,
  output logic [XLEN-1:0]          mem_wdata_o,
  input  logic                     mem_ack_i,
  input  logic [XLEN-1:0]          mem_rdata_i
);

  localparam int CntW = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  lsu_state_e state_q, state_d;

  logic                     we_q, we_d;
  logic [DataAddrWidth-1:0] addr_q, addr_d;
  logic [BE_W-1:0]          be_q, be_d;
  logic [XLEN-1:0]          wdata_q, wdata_d;
  logic [2:0]               funct3_q, funct3_d;
  logic [1:0]               off_q, off_d;
  logic                     err_q, err_d;
  logic [XLEN-1:0]          rdata_q, rdata_d;
  logic [CntW-1:0]          cnt_q, cnt_d;

  logic                     legal;
  logic                     timeout;
  logic [BE_W-1:0]          be_new;
  logic [XLEN-1:0]          wdata_new;
  logic [XLEN-1:0]          ld_data;

  // Upper address bits wrap modulo the memory size.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_i[XLEN-1:DataAddrWidth+2];

  assign legal   = lsu_legal(req_we_i, funct3_i, addr_i[1:0]);
  assign timeout = (cnt_q == CntLast);

  lsu_lane_align u_align (
    .st_size_i  (funct3_i[1:0]),
    .st_off_i   (addr_i[1:0]),
    .st_data_i  (wdata_i),
    .be_o       (be_new),
    .wdata_o    (wdata_new),
    .ld_funct3_i(funct3_q),
    .ld_off_i   (off_q),
    .ld_word_i  (mem_rdata_i),
    .ld_data_o  (ld_data)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid_i) state_d = legal ? BUSY : RESP;
      BUSY:    if (mem_ack_i || timeout) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // An ack on the last allowed BUSY cycle takes priority over the timeout.
  always_comb begin
    we_d     = we_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          err_d = ~legal;
          cnt_d = '0;
          if (legal) begin
            we_d     = req_we_i;
            addr_d   = addr_i[DataAddrWidth+1:2];
            be_d     = be_new;
            wdata_d  = wdata_new;
            funct3_d = funct3_i;
            off_d    = addr_i[1:0];
          end else begin
            rdata_d = '0;
          end
        end
      end
      BUSY: begin
        if (mem_ack_i) begin
          rdata_d = we_q ? '0 : ld_data;
        end else if (timeout) begin
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      off_q    <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
    end
  end

  // Stall is forced low while reset is asserted so an abandoned access releases at once.
  always_comb begin
    mem_req_o   = (state_q == BUSY);
    mem_we_o    = (state_q == BUSY) & we_q;
    mem_addr_o  = addr_q;
    mem_be_o    = be_q;
    mem_wdata_o = wdata_q;
    done_o      = (state_q == RESP);
    err_o       = (state_q == RESP) & err_q;
    rdata_o     = rdata_q;
    stall_o     = rst_i & (((state_q == IDLE) & req_valid_i) | (state_q == BUSY));
  end

endmodule
